// File: rtl/axi_pkg.sv
// Shared AXI encodings, field widths and responder FSM states.
package axi_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Burst shapes this responder cannot serve: reserved type, beats wider than 32 bits, bad WRAP length.
  function automatic logic burst_unsupported(logic [BURST_W-1:0] burst,
                                             logic [SIZE_W-1:0]  size,
                                             logic [LEN_W-1:0]   len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || (size > 3'd2) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/dram_axi_rd_resp_if.sv
// AR/R channel bundle between the LSU (master) and the DRAM read responder (slave).
interface dram_axi_rd_resp_if
  import axi_pkg::*;
#(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 31,
  parameter int unsigned DATA_W = 32
);

  logic [ID_W-1:0]    lsu_axi_arid;
  logic [ADDR_W-1:0]  lsu_axi_araddr;
  logic [LEN_W-1:0]   lsu_axi_arlen;
  logic [SIZE_W-1:0]  lsu_axi_arsize;
  logic [BURST_W-1:0] lsu_axi_arburst;
  logic               lsu_axi_arvalid;
  logic               axi_lsu_arready;
  logic [ID_W-1:0]    axi_lsu_rid;
  logic [DATA_W-1:0]  axi_lsu_rdata;
  logic [RESP_W-1:0]  axi_lsu_rresp;
  logic               axi_lsu_rlast;
  logic               axi_lsu_rvalid;
  logic               lsu_axi_rready;

  modport slave (
    input  lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
    input  lsu_axi_arvalid, lsu_axi_rready,
    output axi_lsu_arready, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast,
    output axi_lsu_rvalid
  );

  modport master (
    output lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
    output lsu_axi_arvalid, lsu_axi_rready,
    input  axi_lsu_arready, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast,
    input  axi_lsu_rvalid
  );

endinterface

// File: rtl/axi_rd_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
module axi_rd_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 31
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic [SIZE_W-1:0]  size,
  input  logic [LEN_W-1:0]   len,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr_c
);

  logic [ADDR_W-1:0] step_c;
  logic [ADDR_W-1:0] wrap_mask_c;
  logic [ADDR_W-1:0] incr_addr_c;

  // WRAP keeps the bits above the (len+1)<<size block and lets the low bits roll over.
  always_comb begin
    step_c      = ADDR_W'(1) << size;
    wrap_mask_c = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr_addr_c = addr + step_c;
    case (burst)
      BURST_INCR: next_addr_c = incr_addr_c;
      BURST_WRAP: next_addr_c = (addr & ~wrap_mask_c) | (incr_addr_c & wrap_mask_c);
      default:    next_addr_c = addr;
    endcase
  end

endmodule

// File: rtl/dram_axi_rd_resp.sv
// AXI4 read responder serving single outstanding bursts from a backdoor-loaded word memory.
module dram_axi_rd_resp
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 31,
  parameter int unsigned MEM_AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  dram_axi_rd_resp_if.slave   axi,
  input  logic                init_wen,
  input  logic [MEM_AW-1:0]   init_addr,
  input  logic [DATA_W-1:0]   init_data
);

  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned HI_LSB = MEM_AW + 2;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e             state_q,   state_d;
  logic               arready_q, arready_d;
  logic [ID_W-1:0]    id_q,      id_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic [SIZE_W-1:0]  size_q,    size_d;
  logic [BURST_W-1:0] burst_q,   burst_d;
  logic               slverr_q,  slverr_d;
  logic [LEN_W-1:0]   cnt_q,     cnt_d;
  logic               fetch_q,   fetch_d;
  logic               rvalid_q,  rvalid_d;
  logic               rlast_q,   rlast_d;
  logic [RESP_W-1:0]  rresp_q,   rresp_d;
  logic [DATA_W-1:0]  rdata_q,   rdata_d;

  logic               ar_hs_c;
  logic               r_hs_c;
  logic               rd_en_c;
  logic [ADDR_W-1:0]  rd_addr_c;
  logic [ADDR_W-1:0]  next_addr_c;
  logic [LEN_W-1:0]   cnt_new_c;
  logic               decerr_c;
  logic [DATA_W-1:0]  mem_rd_c;
  logic               unused_addr_lsb_c;

  axi_rd_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr        (addr_q),
    .size        (size_q),
    .len         (len_q),
    .burst       (burst_q),
    .next_addr_c (next_addr_c)
  );

  assign ar_hs_c           = (state_q == ST_IDLE) && arready_q && axi.lsu_axi_arvalid;
  assign r_hs_c            = rvalid_q && axi.lsu_axi_rready;
  assign decerr_c          = |rd_addr_c[ADDR_W-1:HI_LSB];
  assign mem_rd_c          = mem[rd_addr_c[HI_LSB-1:2]];
  assign unused_addr_lsb_c = ^rd_addr_c[1:0];

  // Backdoor preload; the R path samples the array before this edge, so it sees old data.
  always_ff @(posedge clk) begin
    if (init_wen) begin
      mem[init_addr] <= init_data;
    end
  end

  // Next-state: capture on AR, fetch first beat one cycle later, then fetch on each non-last R handshake.
  always_comb begin
    state_d   = state_q;
    arready_d = 1'b0;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    slverr_d  = slverr_q;
    cnt_d     = cnt_q;
    fetch_d   = 1'b0;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rd_en_c   = 1'b0;
    rd_addr_c = addr_q;
    cnt_new_c = cnt_q;

    case (state_q)
      ST_IDLE: begin
        arready_d = !ar_hs_c;
        if (ar_hs_c) begin
          state_d  = ST_BURST;
          id_d     = axi.lsu_axi_arid;
          addr_d   = axi.lsu_axi_araddr;
          len_d    = axi.lsu_axi_arlen;
          size_d   = axi.lsu_axi_arsize;
          burst_d  = axi.lsu_axi_arburst;
          slverr_d = burst_unsupported(axi.lsu_axi_arburst, axi.lsu_axi_arsize,
                                       axi.lsu_axi_arlen);
          cnt_d    = axi.lsu_axi_arlen;
          fetch_d  = 1'b1;
        end
      end
      default: begin
        if (fetch_q) begin
          rd_en_c = 1'b1;
        end else if (r_hs_c) begin
          if (rlast_q) begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            rd_en_c   = 1'b1;
            rd_addr_c = next_addr_c;
            cnt_new_c = cnt_q - LEN_W'(1);
          end
        end
      end
    endcase

    if (rd_en_c) begin
      addr_d   = rd_addr_c;
      cnt_d    = cnt_new_c;
      rvalid_d = 1'b1;
      rlast_d  = (cnt_new_c == '0);
      if (slverr_q) begin
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end else if (decerr_c) begin
        rresp_d = RESP_DECERR;
        rdata_d = '0;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = mem_rd_c;
      end
    end
  end

  // State and registered R/AR outputs; reset drops any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      slverr_q  <= 1'b0;
      cnt_q     <= '0;
      fetch_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      slverr_q  <= slverr_d;
      cnt_q     <= cnt_d;
      fetch_q   <= fetch_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi.axi_lsu_arready = arready_q;
  assign axi.axi_lsu_rid     = id_q;
  assign axi.axi_lsu_rdata   = rdata_q;
  assign axi.axi_lsu_rresp   = rresp_q;
  assign axi.axi_lsu_rlast   = rlast_q;
  assign axi.axi_lsu_rvalid  = rvalid_q;

endmodule

// File: tb/tb_dram_axi_rd_resp.sv
// Directed and random bursts against a queue-based AXI read model.
module tb_dram_axi_rd_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_wen;
  logic [9:0]  init_addr;
  logic [31:0] init_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mdl_mem [1024];
  logic [31:0] exp_d [$];
  logic [1:0]  exp_r [$];

  dram_axi_rd_resp_if #(.ID_W(8), .ADDR_W(31), .DATA_W(32)) ifc ();

  dram_axi_rd_resp dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (ifc),
    .init_wen  (init_wen),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int unsigned idx, input logic [31:0] v);
    init_wen  = 1'b1;
    init_addr = 10'(idx);
    init_data = v;
    @(posedge clk); #1;
    init_wen  = 1'b0;
    mdl_mem[idx] = v;
  endtask

  // Expected beats from AXI address rules and the error priority.
  task automatic build_exp(input int unsigned addr, input int unsigned len,
                           input int unsigned size, input int unsigned burst);
    int unsigned bytes, total, a, base;
    bit slv;
    bytes = 1 << size;
    total = (len + 1) * bytes;
    slv = (burst == 3) || (size > 2) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    exp_d.delete();
    exp_r.delete();
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 0)      a = addr;
      else if (burst == 1) a = addr + i * bytes;
      else begin
        base = (addr / total) * total;
        a = base + ((addr - base) + i * bytes) % total;
      end
      a = a & 32'h7FFF_FFFF;
      if (slv) begin
        exp_d.push_back(32'h0); exp_r.push_back(2'b10);
      end else if ((a >> 12) != 0) begin
        exp_d.push_back(32'h0); exp_r.push_back(2'b11);
      end else begin
        exp_d.push_back(mdl_mem[(a >> 2) & 1023]); exp_r.push_back(2'b00);
      end
    end
  endtask

  // mode: 0 rready held, 1 pattern 1,0,0, 2 random; abort_at>0 resets after that many beats.
  task automatic run_burst(input int unsigned id, input int unsigned addr, input int unsigned len,
                           input int unsigned size, input int unsigned burst,
                           input int unsigned mode, input int unsigned abort_at);
    int unsigned n, k, cyc;
    logic rr;
    n = len + 1;
    k = 0;
    build_exp(addr, len, size, burst);
    cyc = 0;
    while (ifc.axi_lsu_arready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("ar_wait", 64'(ifc.axi_lsu_arready), 64'd1);
    ifc.lsu_axi_arvalid = 1'b1;
    ifc.lsu_axi_arid    = 8'(id);
    ifc.lsu_axi_araddr  = 31'(addr);
    ifc.lsu_axi_arlen   = 8'(len);
    ifc.lsu_axi_arsize  = 3'(size);
    ifc.lsu_axi_arburst = 2'(burst);
    @(posedge clk); #1;
    ifc.lsu_axi_arvalid = 1'b0;
    chk("ar_drop", 64'(ifc.axi_lsu_arready), 64'd0);
    chk("rv_lat0", 64'(ifc.axi_lsu_rvalid), 64'd0);
    @(posedge clk); #1;
    chk("rv_lat1", 64'(ifc.axi_lsu_rvalid), 64'd1);
    cyc = 0;
    while (k < n && cyc < 400) begin
      if (abort_at != 0 && k == abort_at) break;
      if (mode == 0)      rr = 1'b1;
      else if (mode == 1) rr = (cyc % 3 == 0);
      else                rr = 1'($urandom_range(0, 1));
      ifc.lsu_axi_rready = rr;
      chk("arready_busy", 64'(ifc.axi_lsu_arready), 64'd0);
      chk("rvalid", 64'(ifc.axi_lsu_rvalid), 64'd1);
      if (ifc.axi_lsu_rvalid === 1'b1) begin
        chk("rdata", 64'(ifc.axi_lsu_rdata), 64'(exp_d[k]));
        chk("rresp", 64'(ifc.axi_lsu_rresp), 64'(exp_r[k]));
        chk("rid",   64'(ifc.axi_lsu_rid),   64'(id & 8'hFF));
        chk("rlast", 64'(ifc.axi_lsu_rlast), 64'(k == n - 1));
        if (rr) k++;
      end
      @(posedge clk); #1; cyc++;
    end
    ifc.lsu_axi_rready = 1'b0;
    if (abort_at != 0) begin
      rst = 1'b1;
      #1;
      chk("abort_rvalid",  64'(ifc.axi_lsu_rvalid),  64'd0);
      chk("abort_arready", 64'(ifc.axi_lsu_arready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rel_arready0", 64'(ifc.axi_lsu_arready), 64'd0);
      @(posedge clk); #1;
      chk("rel_arready1", 64'(ifc.axi_lsu_arready), 64'd1);
    end else begin
      chk("beats_done",  64'(k), 64'(n));
      chk("end_rvalid",  64'(ifc.axi_lsu_rvalid),  64'd0);
      chk("end_arready", 64'(ifc.axi_lsu_arready), 64'd0);
      @(posedge clk); #1;
      chk("gap_arready", 64'(ifc.axi_lsu_arready), 64'd1);
    end
  endtask

  initial begin
    int unsigned sz, bu, ln, ad;
    rst = 1'b1;
    init_wen = 1'b0; init_addr = '0; init_data = '0;
    ifc.lsu_axi_arvalid = 1'b0; ifc.lsu_axi_arid = '0; ifc.lsu_axi_araddr = '0;
    ifc.lsu_axi_arlen = '0; ifc.lsu_axi_arsize = '0; ifc.lsu_axi_arburst = '0;
    ifc.lsu_axi_rready = 1'b0;
    #1;
    chk("rst_arready", 64'(ifc.axi_lsu_arready), 64'd0);
    chk("rst_rvalid",  64'(ifc.axi_lsu_rvalid),  64'd0);
    chk("rst_rlast",   64'(ifc.axi_lsu_rlast),   64'd0);
    chk("rst_rid",     64'(ifc.axi_lsu_rid),     64'd0);
    chk("rst_rdata",   64'(ifc.axi_lsu_rdata),   64'd0);
    chk("rst_rresp",   64'(ifc.axi_lsu_rresp),   64'd0);

    for (int i = 0; i < 1024; i++) wr(i, $urandom());
    for (int i = 0; i < 16; i++) wr(i, 32'hA0 + 32'(i));
    rst = 1'b0;
    chk("rel_arready0", 64'(ifc.axi_lsu_arready), 64'd0);
    @(posedge clk); #1;
    chk("rel_arready1", 64'(ifc.axi_lsu_arready), 64'd1);

    run_burst(8'h05, 32'h0,    3, 2, 1, 0, 0);
    run_burst(8'h11, 32'h38,   3, 2, 2, 0, 0);
    run_burst(8'h22, 32'h8,    2, 2, 0, 0, 0);
    run_burst(8'h33, 32'h10,   7, 2, 1, 1, 0);
    run_burst(8'h44, 32'h1000, 1, 2, 1, 0, 0);
    run_burst(8'h55, 32'h20,   2, 2, 2, 0, 0);
    run_burst(8'h66, 32'h20,   1, 2, 3, 0, 0);
    run_burst(8'h77, 32'h20,   1, 3, 1, 0, 0);
    run_burst(8'h88, 32'h0,    7, 2, 1, 0, 2);
    run_burst(8'h99, 32'h20,   3, 2, 1, 0, 0);

    for (int t = 0; t < 30; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      bu = $urandom_range(0, 3);
      if (bu == 2 && $urandom_range(0, 3) != 0) ln = (2 << $urandom_range(0, 3)) - 1;
      else ln = $urandom_range(0, 15);
      ad = $urandom_range(0, 4095 + 512) & ~((32'd1 << sz) - 1);
      run_burst($urandom_range(0, 255), ad, ln, sz, bu, 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
